// File: rtl/btn_conditioner.sv
// Button front end: two-flop synchroniser, two-edge debounce, press/release/long/repeat strobes.
// Press is accepted DEBOUNCE_CYCLES+3 edges after btn_in rises; every output is registered.
module btn_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned HOLD_CYCLES     = 50000000,
  parameter int unsigned REPEAT_CYCLES   = 10000000,
  parameter int unsigned CNT_W           = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  typedef enum logic [2:0] {
    ST_RELEASED,
    ST_PRESS_CHK,
    ST_PRESSED,
    ST_REPEAT,
    ST_RELEASE_CHK
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  logic             s1_q, s2_q;
  logic             btn_s;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] dcnt_q, dcnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic             held_q, held_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             long_q, long_d;
  logic             repeat_q, repeat_d;

  assign btn_s = s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      state_q   <= ST_RELEASED;
      dcnt_q    <= '0;
      hcnt_q    <= '0;
      held_q    <= 1'b0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      s1_q      <= btn_in;
      s2_q      <= s1_q;
      state_q   <= state_d;
      dcnt_q    <= dcnt_d;
      hcnt_q    <= hcnt_d;
      held_q    <= held_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    dcnt_d    = dcnt_q;
    hcnt_d    = hcnt_q;
    held_d    = held_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;

    case (state_q)
      ST_RELEASED: begin
        level_d = 1'b0;
        if (btn_s) begin
          state_d = ST_PRESS_CHK;
          dcnt_d  = '0;
        end
      end

      ST_PRESS_CHK: begin
        if (!btn_s) begin
          state_d = ST_RELEASED;
        end else if (dcnt_q == DEB_LAST) begin
          state_d = ST_PRESSED;
          level_d = 1'b1;
          press_d = 1'b1;
          hcnt_d  = '0;
          held_d  = 1'b0;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end

      ST_PRESSED: begin
        if (!btn_s) begin
          state_d = ST_RELEASE_CHK;
          dcnt_d  = '0;
        end else if (hcnt_q == HOLD_LAST) begin
          state_d  = ST_REPEAT;
          long_d   = 1'b1;
          repeat_d = 1'b1;
          hcnt_d   = '0;
          held_d   = 1'b1;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end

      ST_REPEAT: begin
        if (!btn_s) begin
          state_d = ST_RELEASE_CHK;
          dcnt_d  = '0;
        end else if (hcnt_q == REP_LAST) begin
          repeat_d = 1'b1;
          hcnt_d   = '0;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end

      ST_RELEASE_CHK: begin
        // A bounce back to high resumes the hold timer where it stopped.
        if (btn_s) begin
          state_d = held_q ? ST_REPEAT : ST_PRESSED;
        end else if (dcnt_q == DEB_LAST) begin
          state_d   = ST_RELEASED;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_RELEASED;
        level_d = 1'b0;
      end
    endcase
  end

  assign level         = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;
  assign repeat_pulse  = repeat_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: vector table, hand sequences and random stimulus against a reference model.
module tb_btn_conditioner;

  logic clk = 1'b0;
  logic rst;
  logic btn_in;
  logic level_a, press_a, rel_a, long_a, rep_a;
  logic level_b, press_b, rel_b, long_b, rep_b;
  logic [4:0] out_a, out_b;

  always #5 clk = ~clk;

  btn_conditioner #(.DEBOUNCE_CYCLES(4), .HOLD_CYCLES(20), .REPEAT_CYCLES(5), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .btn_in(btn_in), .level(level_a), .press_pulse(press_a),
    .release_pulse(rel_a), .long_pulse(long_a), .repeat_pulse(rep_a));

  btn_conditioner #(.DEBOUNCE_CYCLES(1), .HOLD_CYCLES(1), .REPEAT_CYCLES(1), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .btn_in(btn_in), .level(level_b), .press_pulse(press_b),
    .release_pulse(rel_b), .long_pulse(long_b), .repeat_pulse(rep_b));

  assign out_a = {level_a, press_a, rel_a, long_a, rep_a};
  assign out_b = {level_b, press_b, rel_b, long_b, rep_b};

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: sync delay line, run length of samples disagreeing with the
  // accepted level, and an accumulated hold time that pauses during release bounce.
  int m_s1[2], m_s2[2], m_lvl[2], m_run[2], m_hold[2];
  logic [4:0] m_exp[2];

  task automatic model_step(input int i, input bit r, input bit b);
    int d, h, rp, bs;
    bit pp, rl, lg, rep;
    d = (i == 0) ? 4 : 1;
    h = (i == 0) ? 20 : 1;
    rp = (i == 0) ? 5 : 1;
    pp = 0; rl = 0; lg = 0; rep = 0;
    if (r) begin
      m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_run[i] = 0; m_hold[i] = 0;
      m_exp[i] = 5'b0;
    end else begin
      bs = m_s2[i];
      m_s2[i] = m_s1[i];
      m_s1[i] = b;
      if (bs != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == d + 1) begin
          m_lvl[i] = bs;
          m_run[i] = 0;
          if (bs != 0) begin
            pp = 1;
            m_hold[i] = 0;
          end else begin
            rl = 1;
          end
        end
      end else begin
        if (m_lvl[i] != 0 && m_run[i] == 0) begin
          m_hold[i]++;
          if (m_hold[i] == h) begin
            lg = 1; rep = 1;
          end else if (m_hold[i] > h && ((m_hold[i] - h) % rp) == 0) begin
            rep = 1;
          end
        end
        m_run[i] = 0;
      end
      m_exp[i] = {m_lvl[i] != 0, pp, rl, lg, rep};
    end
  endtask

  task automatic cmp(input string nm, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s cycle %0d got lvl/prs/rel/lng/rep=%b want %b", nm, cyc, act, exp);
    end
  endtask

  task automatic step(input bit r, input bit b);
    rst = r;
    btn_in = b;
    @(posedge clk);
    model_step(0, r, b);
    model_step(1, r, b);
    #1;
    cyc++;
    cmp("model_a", out_a, m_exp[0]);
    cmp("model_b", out_b, m_exp[1]);
  endtask

  typedef struct {
    bit         rst_v;
    bit         btn_v;
    logic [4:0] exp_a;
  } vec_t;

  vec_t vt[$];

  task automatic add(input bit r, input bit b, input logic [4:0] e);
    vec_t v;
    v.rst_v = r;
    v.btn_v = b;
    v.exp_a = e;
    vt.push_back(v);
  endtask

  function automatic logic [4:0] press_release_exp(input int k, input int press_k, input int rel_k);
    if (k < press_k) return 5'b00000;
    if (k == press_k) return 5'b11000;
    if (k < rel_k) return 5'b10000;
    if (k == rel_k) return 5'b00100;
    return 5'b00000;
  endfunction

  initial begin
    logic [15:0] glitch_pat;
    logic [4:0]  ea, eb;
    bit          b;
    int          len;

    rst = 1'b1;
    btn_in = 1'b0;

    // Reset and idle
    for (int k = 0; k < 3; k++) add(1'b1, 1'b0, 5'b0);
    for (int k = 0; k < 3; k++) add(1'b0, 1'b0, 5'b0);
    // Clean press: 15 high then low; press at edge 7, release at edge 22
    for (int k = 1; k <= 25; k++) add(1'b0, k <= 15, press_release_exp(k, 7, 22));
    // Glitches: 3-cycle pulse, then single-cycle toggling
    glitch_pat = 16'b0000_0101_0000_0111;
    for (int k = 0; k < 16; k++) add(1'b0, glitch_pat[k], 5'b0);
    // Release bounce: 12 high, 2 low, 2 high, 2 low, 2 high, stable low from edge 21
    for (int k = 1; k <= 32; k++) begin
      b = (k <= 12) || (k >= 15 && k <= 16) || (k >= 19 && k <= 20);
      add(1'b0, b, press_release_exp(k, 7, 27));
    end

    foreach (vt[i]) begin
      step(vt[i].rst_v, vt[i].btn_v);
      cmp("vector", out_a, vt[i].exp_a);
    end

    // Long press with auto-repeat on both configurations
    for (int k = 1; k <= 55; k++) begin
      step(1'b0, k <= 45);
      ea = {k >= 7 && k < 52, k == 7, k == 52, k == 27,
            k >= 27 && k <= 47 && ((k - 27) % 5) == 0};
      eb = {k >= 4 && k < 49, k == 4, k == 49, k == 5, k >= 5 && k <= 47};
      cmp("long_a", out_a, ea);
      cmp("minparam_b", out_b, eb);
    end

    // Reset while in auto-repeat with the button still down
    for (int k = 1; k <= 30; k++) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    cmp("rst_mid_a", out_a, 5'b0);
    cmp("rst_mid_b", out_b, 5'b0);
    for (int k = 1; k <= 10; k++) begin
      step(1'b0, 1'b1);
      cmp("repress_a", out_a, press_release_exp(k, 7, 1000));
    end
    for (int k = 0; k < 10; k++) step(1'b0, 1'b0);

    // Random bursts with occasional reset
    b = 1'b0;
    for (int n = 0; n < 300; n++) begin
      b = ~b;
      len = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 6) : $urandom_range(1, 60);
      for (int k = 0; k < len; k++) step($urandom_range(0, 199) == 0, b);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
